// File: rtl/aff7seg_pkg.sv
// aff7seg_pkg: shared types and constants for the 3-digit 7-segment scanner.
// Contents: scan state enum, active-high segment patterns, anode one-hot codes.
// No logic; imported by dec7seg and aff7seg_mux3.
package aff7seg_pkg;

  // Scan slot currently being driven.
  typedef enum logic [1:0] {
    S_U = 2'd0,  // units
    S_D = 2'd1,  // tens
    S_C = 2'd2   // hundreds
  } state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Active-high anode one-hot codes: an[0]=units, an[1]=tens, an[2]=hundreds.
  localparam logic [2:0] AN_U   = 3'b001;
  localparam logic [2:0] AN_D   = 3'b010;
  localparam logic [2:0] AN_C   = 3'b100;
  localparam logic [2:0] AN_OFF = 3'b000;

endpackage

// File: rtl/aff7seg_mux3_dec7seg.sv
// dec7seg: BCD digit to active-high 7-segment pattern; non-BCD codes show a dash.
// Latency: purely combinational.
// Backpressure: none.
// Ports: bcd (4-bit digit in), seg (7-bit {g,f,e,d,c,b,a} out, active-high).
module dec7seg
  import aff7seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/aff7seg_mux3.sv
// aff7seg_mux3: 3-digit multiplexed 7-segment driver with blank guard and leading-zero suppression.
// Latency: charge at edge k loads shadows at k; pins reflect them at edge k+1.
// Backpressure: none; charge is accepted every cycle it is high.
// Ports: clk, rst_n (async active-low); centaines/dizaines/unites (BCD in), charge (load strobe),
//        blank_zeros (leading-zero suppression); seg/dp/an (board pins), slot_tick (slot-change pulse).
module aff7seg_mux3
  import aff7seg_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] centaines,
  input  logic [3:0] dizaines,
  input  logic [3:0] unites,
  input  logic       charge,
  input  logic       blank_zeros,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] an,
  output logic       slot_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // XOR masks turning active-high values into pin levels; also the inactive pin levels.
  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_INV  = (AN_ACTIVE_LOW  != 0) ? 3'b111 : 3'b000;

  logic [DIV_W-1:0] div_q, div_d;
  state_t           state_q, state_d;
  logic [3:0]       c_q, d_q, u_q;
  logic [3:0]       c_d, d_d, u_d;
  logic             tick;
  logic             slot_tick_q;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;

  logic [3:0]       digit;
  logic [6:0]       seg_raw;
  logic [2:0]       an_hot;
  logic             slot_on;
  logic             guard;

  // Refresh divider and slot advance.
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_U:     state_d = S_D;
        S_D:     state_d = S_C;
        S_C:     state_d = S_U;
        default: state_d = S_U;
      endcase
    end
  end

  // Shadow digits: reload whenever charge is high, otherwise hold.
  assign c_d = charge ? centaines : c_q;
  assign d_d = charge ? dizaines  : d_q;
  assign u_d = charge ? unites    : u_q;

  // Digit mux, anode select and leading-zero suppression for the current slot.
  // Non-BCD codes are nonzero, so they never trigger suppression.
  always_comb begin
    digit   = u_q;
    an_hot  = AN_U;
    slot_on = 1'b1;
    case (state_q)
      S_U: begin
        digit   = u_q;
        an_hot  = AN_U;
        slot_on = 1'b1;
      end
      S_D: begin
        digit   = d_q;
        an_hot  = AN_D;
        slot_on = !(blank_zeros && (c_q == 4'd0) && (d_q == 4'd0));
      end
      S_C: begin
        digit   = c_q;
        an_hot  = AN_C;
        slot_on = !(blank_zeros && (c_q == 4'd0));
      end
      default: begin
        digit   = u_q;
        an_hot  = AN_U;
        slot_on = 1'b1;
      end
    endcase
  end

  dec7seg u_dec (
    .bcd (digit),
    .seg (seg_raw)
  );

  // Anti-ghosting: keep everything dark for the first BLANK_CYC cycles of a slot.
  assign guard = (32'(div_q) < BLANK_CYC);

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (!guard && slot_on) begin
      seg_d = seg_raw;
      an_d  = an_hot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      state_q     <= S_U;
      c_q         <= 4'd0;
      d_q         <= 4'd0;
      u_q         <= 4'd0;
      slot_tick_q <= 1'b0;
      seg_q       <= SEG_INV;
      an_q        <= AN_INV;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      c_q         <= c_d;
      d_q         <= d_d;
      u_q         <= u_d;
      slot_tick_q <= tick;
      seg_q       <= seg_d ^ SEG_INV;
      an_q        <= an_d ^ AN_INV;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign slot_tick = slot_tick_q;
  // Decimal point is never lit: tie to the inactive pin level.
  assign dp        = SEG_INV[0];

endmodule

// File: tb/tb_aff7seg_mux3.sv
// tb_aff7seg_mux3: directed, table-driven bench for aff7seg_mux3 (CLK_DIV=4, BLANK_CYC=1, active-low pins).
// Latency: pins are sampled 1 ns after each rising edge against a cycle model of divider/slot.
// Backpressure: none.
module tb_aff7seg_mux3;

  logic       clk;
  logic       rst_n;
  logic [3:0] centaines, dizaines, unites;
  logic       charge, blank_zeros;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] an;
  logic       slot_tick;

  aff7seg_mux3 #(
    .CLK_DIV        (4),
    .BLANK_CYC      (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .centaines   (centaines),
    .dizaines    (dizaines),
    .unites      (unites),
    .charge      (charge),
    .blank_zeros (blank_zeros),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .slot_tick   (slot_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One load vector with hand-computed expectations per slot (index 0=units, 1=tens, 2=hundreds).
  typedef struct packed {
    logic [3:0]      c;
    logic [3:0]      d;
    logic [3:0]      u;
    logic            bz;
    logic [2:0][6:0] seg;  // active-high segments shown in each slot
    logic [2:0]      on;   // slot lit (not suppressed)
  } vec_t;

  vec_t vecs [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side model of divider, slot and currently displayed expectations.
  int              mdiv;
  int              mslot;
  logic [2:0][6:0] cur_seg;
  logic [2:0]      cur_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock, update the model and optionally compare all pins.
  task automatic step(input bit check);
    logic [2:0] e_an;
    logic [6:0] e_seg;
    logic       e_tick;
    int         pdiv, pslot;
    pdiv  = mdiv;
    pslot = mslot;
    @(posedge clk);
    if (pdiv < 1 || !cur_on[pslot]) begin
      e_an  = 3'b111;
      e_seg = 7'h7F;
    end else begin
      e_an  = ~(3'b001 << pslot);
      e_seg = ~cur_seg[pslot];
    end
    e_tick = (pdiv == 3);
    if (pdiv == 3) begin
      mdiv  = 0;
      mslot = (mslot + 1) % 3;
    end else begin
      mdiv = mdiv + 1;
    end
    #1;
    if (check) begin
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("slot_tick", 32'(slot_tick), 32'(e_tick));
      chk("dp", 32'(dp), 32'd1);
    end
  endtask

  task automatic model_reset();
    mdiv    = 0;
    mslot   = 0;
    cur_seg = {7'h3F, 7'h3F, 7'h3F};
    cur_on  = blank_zeros ? 3'b001 : 3'b111;
  endtask

  task automatic load(input vec_t v, input bit check);
    centaines   = v.c;
    dizaines    = v.d;
    unites      = v.u;
    blank_zeros = v.bz;
    charge      = 1'b1;
    step(check);
    cur_seg = v.seg;
    cur_on  = v.on;
    charge  = 1'b0;
  endtask

  int tick_cnt;

  initial begin
    //                c      d      u      bz    seg {C, D, U}                on {C,D,U}
    vecs[0] = '{4'd1, 4'd2, 4'd3, 1'b0, {7'h06, 7'h5B, 7'h4F}, 3'b111};
    vecs[1] = '{4'd0, 4'd0, 4'd7, 1'b1, {7'h3F, 7'h3F, 7'h07}, 3'b001};
    vecs[2] = '{4'd0, 4'd0, 4'd7, 1'b0, {7'h3F, 7'h3F, 7'h07}, 3'b111};
    vecs[3] = '{4'd0, 4'd4, 4'd0, 1'b1, {7'h3F, 7'h66, 7'h3F}, 3'b011};
    vecs[4] = '{4'hC, 4'd0, 4'd0, 1'b1, {7'h40, 7'h3F, 7'h3F}, 3'b111};
    vecs[5] = '{4'd0, 4'd0, 4'd0, 1'b1, {7'h3F, 7'h3F, 7'h3F}, 3'b001};
    vecs[6] = '{4'd9, 4'd8, 4'd5, 1'b0, {7'h6F, 7'h7F, 7'h6D}, 3'b111};
    vecs[7] = '{4'd0, 4'hA, 4'd6, 1'b1, {7'h3F, 7'h40, 7'h7D}, 3'b011};

    rst_n       = 1'b0;
    centaines   = 4'd0;
    dizaines    = 4'd0;
    unites      = 4'd0;
    charge      = 1'b0;
    blank_zeros = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", 32'(an), 32'h7);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_tick", 32'(slot_tick), 32'h0);
    chk("reset_dp", 32'(dp), 32'h1);

    // Release and watch the idle scan of "0" in the units slot.
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1);
      if (slot_tick) tick_cnt++;
    end
    chk("tick_count_16cyc", 32'(tick_cnt), 32'd4);

    // Table: load each vector (check suppressed on the load edge since
    // blank_zeros acts immediately on the old shadows), then watch >1 frame.
    // 14 cycles per vector shifts the load phase each time.
    for (int v = 0; v < 8; v++) begin
      load(vecs[v], 1'b0);
      for (int i = 0; i < 14; i++) step(1'b1);
    end

    // Charge held high with changing digits: shadows follow every cycle.
    load(vecs[0], 1'b0);
    load(vecs[6], 1'b1);
    load(vecs[2], 1'b1);
    load(vecs[0], 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1);

    // Mid-slot reset: pins go dark immediately, scan restarts from units.
    for (int i = 0; i < 2; i++) step(1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_an", 32'(an), 32'h7);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_tick", 32'(slot_tick), 32'h0);
    blank_zeros = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // First edge after release: still dark (divider 0); second: units lit with "0".
    step(1'b1);
    chk("first_an_dark", 32'(an), 32'h7);
    step(1'b1);
    chk("first_an_units", 32'(an), 32'h6);
    chk("first_seg_zero", 32'(seg), 32'h40);
    for (int i = 0; i < 14; i++) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
